// File: rtl/oversample_voter_if.sv
// Bus between the RX control FSM and the oversampling majority voter.
//   master : drives rx_in, dat_samp_en, edge_cnt, prescale; observes the vote
//   slave  : the voter; returns sampled_bit, bit_valid, noise_err, cfg_err
interface oversample_voter_if #(
  parameter int PRESC_W = 6
);
  logic               rx_in;
  logic               dat_samp_en;
  logic [PRESC_W-1:0] edge_cnt;
  logic [PRESC_W-1:0] prescale;
  logic               sampled_bit;
  logic               bit_valid;
  logic               noise_err;
  logic               cfg_err;

  modport master (
    output rx_in, dat_samp_en, edge_cnt, prescale,
    input  sampled_bit, bit_valid, noise_err, cfg_err
  );

  modport slave (
    input  rx_in, dat_samp_en, edge_cnt, prescale,
    output sampled_bit, bit_valid, noise_err, cfg_err
  );
endinterface

// File: rtl/oversample_voter.sv
// Oversampling majority voter for a UART-style receiver.
// Takes NUM_SAMP samples of the (optionally synchronised) serial line centred
// on the middle of the bit period and votes on them one edge past the last
// sample point.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   bus   : oversample_voter_if.slave
//           in : rx_in, dat_samp_en, edge_cnt, prescale
//           out: sampled_bit, bit_valid (1-cycle strobe), noise_err, cfg_err
module oversample_voter #(
  parameter int PRESC_W  = 6,
  parameter int NUM_SAMP = 3,
  parameter int SYNC_EN  = 1
) (
  input  logic               clk,
  input  logic               rst,
  oversample_voter_if.slave  bus
);

  localparam int H     = (NUM_SAMP - 1) / 2;
  localparam int CNT_W = $clog2(NUM_SAMP + 1);
  localparam int EW    = PRESC_W + 1;

  typedef logic [EW-1:0]    ew_t;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic vote_bit(input cnt_t ones);
    return ones > cnt_t'(H);
  endfunction

  function automatic logic vote_noise(input cnt_t ones);
    return (ones != '0) && (ones != cnt_t'(NUM_SAMP));
  endfunction

  logic rx_s;

  // Input synchroniser stage
  if (SYNC_EN != 0) begin : g_sync
    logic sync1_q, sync2_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= bus.rx_in;
        sync2_q <= sync1_q;
      end
    end
    assign rx_s = sync2_q;
  end else begin : g_nosync
    assign rx_s = bus.rx_in;
  end

  logic [PRESC_W-1:0] edge_q;
  cnt_t ones_q, ones_d;
  cnt_t taken_q, taken_d;
  logic bit_q, bit_d;
  logic noise_q, noise_d;
  logic valid_q, valid_d;
  logic cfg_q, cfg_d;

  // One extra bit of headroom so centre/offset sums never wrap.
  ew_t edge_w, c_w, h_w, v_w;
  logic fresh, in_win, at_vote;

  assign edge_w  = {1'b0, bus.edge_cnt};
  assign c_w     = {1'b0, bus.prescale} >> 1;
  assign h_w     = ew_t'(H);
  assign v_w     = c_w + h_w + ew_t'(1);
  // Lower bound written as edge+H >= C to avoid subtracting below zero.
  assign in_win  = ((edge_w + h_w) >= c_w) && (edge_w <= (c_w + h_w));
  assign at_vote = (edge_w == v_w);
  // A stalled edge counter must not re-trigger a sample or vote.
  assign fresh   = (bus.edge_cnt != edge_q);
  assign cfg_d   = ({1'b0, bus.prescale} < ew_t'(NUM_SAMP + 3));

  always_comb begin
    ones_d  = ones_q;
    taken_d = taken_q;
    bit_d   = bit_q;
    noise_d = noise_q;
    valid_d = 1'b0;
    if (cfg_q || !bus.dat_samp_en || (bus.edge_cnt == '0)) begin
      ones_d  = '0;
      taken_d = '0;
    end else if (fresh && at_vote) begin
      // Vote only if every sample point of this period was captured.
      if (taken_q == cnt_t'(NUM_SAMP)) begin
        bit_d   = vote_bit(ones_q);
        noise_d = vote_noise(ones_q);
        valid_d = 1'b1;
      end
      ones_d  = '0;
      taken_d = '0;
    end else if (fresh && in_win && (taken_q != cnt_t'(NUM_SAMP))) begin
      taken_d = taken_q + cnt_t'(1);
      ones_d  = ones_q + cnt_t'(rx_s);
    end
  end

  // Accumulator / vote register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q  <= '0;
      ones_q  <= '0;
      taken_q <= '0;
      bit_q   <= 1'b0;
      noise_q <= 1'b0;
      valid_q <= 1'b0;
      cfg_q   <= 1'b0;
    end else begin
      edge_q  <= bus.edge_cnt;
      ones_q  <= ones_d;
      taken_q <= taken_d;
      bit_q   <= bit_d;
      noise_q <= noise_d;
      valid_q <= valid_d;
      cfg_q   <= cfg_d;
    end
  end

  assign bus.sampled_bit = bit_q;
  assign bus.bit_valid   = valid_q;
  assign bus.noise_err   = noise_q;
  assign bus.cfg_err     = cfg_q;

endmodule

// File: tb/tb_oversample_voter.sv
module tb_oversample_voter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx;
  logic       en;
  logic [5:0] ec;
  logic [5:0] ps;

  oversample_voter_if #(.PRESC_W(6)) if3 ();
  oversample_voter_if #(.PRESC_W(6)) if5 ();
  oversample_voter_if #(.PRESC_W(6)) ifs ();

  assign if3.rx_in = rx;  assign if3.dat_samp_en = en;
  assign if3.edge_cnt = ec; assign if3.prescale = ps;
  assign if5.rx_in = rx;  assign if5.dat_samp_en = en;
  assign if5.edge_cnt = ec; assign if5.prescale = ps;
  assign ifs.rx_in = rx;  assign ifs.dat_samp_en = en;
  assign ifs.edge_cnt = ec; assign ifs.prescale = ps;

  oversample_voter #(.PRESC_W(6), .NUM_SAMP(3), .SYNC_EN(0)) u_v3 (.clk(clk), .rst(rst), .bus(if3));
  oversample_voter #(.PRESC_W(6), .NUM_SAMP(5), .SYNC_EN(0)) u_v5 (.clk(clk), .rst(rst), .bus(if5));
  oversample_voter #(.PRESC_W(6), .NUM_SAMP(3), .SYNC_EN(1)) u_vs (.clk(clk), .rst(rst), .bus(ifs));

  logic [2:0] o_valid, o_bit, o_noise, o_cfg;
  assign o_valid = {ifs.bit_valid,   if5.bit_valid,   if3.bit_valid};
  assign o_bit   = {ifs.sampled_bit, if5.sampled_bit, if3.sampled_bit};
  assign o_noise = {ifs.noise_err,   if5.noise_err,   if3.noise_err};
  assign o_cfg   = {ifs.cfg_err,     if5.cfg_err,     if3.cfg_err};

  int n_run  = 0;
  int n_fail = 0;

  int ns_tab [3];
  int sy_tab [3];

  // Reference model: keeps the list of samples taken this period and votes
  // on that list when the vote point is reached.
  bit m_bit [3], m_valid [3], m_noise [3], m_cfg [3];
  int m_prev [3];
  bit m_d1 [3], m_d2 [3];
  int m_n [3];
  bit m_s [3][8];

  bit rx_pat [64];
  int vcount [3];
  int vat [3];

  task automatic model_step(input int i);
    int c, h, v, e, ones, ns;
    bit rxs, nvalid;
    if (rst) begin
      m_bit[i] = 0; m_valid[i] = 0; m_noise[i] = 0; m_cfg[i] = 0;
      m_prev[i] = 0; m_d1[i] = 0; m_d2[i] = 0; m_n[i] = 0;
      return;
    end
    ns = ns_tab[i];
    e  = int'(ec);
    c  = int'(ps) / 2;
    h  = (ns - 1) / 2;
    v  = c + h + 1;
    rxs = (sy_tab[i] != 0) ? m_d2[i] : rx;
    nvalid = 0;
    if (m_cfg[i] || !en || e == 0) begin
      m_n[i] = 0;
    end else if (e != m_prev[i] && e == v) begin
      if (m_n[i] == ns) begin
        ones = 0;
        for (int k = 0; k < m_n[i]; k++) ones += int'(m_s[i][k]);
        m_bit[i]   = (2 * ones > ns);
        m_noise[i] = (ones != 0 && ones != ns);
        nvalid = 1;
      end
      m_n[i] = 0;
    end else if (e != m_prev[i] && e >= c - h && e <= c + h && m_n[i] < ns) begin
      m_s[i][m_n[i]] = rxs;
      m_n[i]++;
    end
    m_valid[i] = nvalid;
    m_cfg[i]   = (int'(ps) < ns + 3);
    m_prev[i]  = e;
    m_d2[i]    = m_d1[i];
    m_d1[i]    = rx;
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge clk);
    #1;
  endtask

  task automatic period(input int p);
    for (int e = 0; e < p; e++) begin
      ec = 6'(e);
      rx = rx_pat[e];
      tick();
      for (int i = 0; i < 3; i++)
        if (o_valid[i]) begin vcount[i]++; vat[i] = e; end
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin vcount[i] = 0; vat[i] = -1; end
  endtask

  task automatic test_reset();
    rst = 1; rx = 0; en = 0; ec = 0; ps = 6'd8;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      n_run += 4;
      if (o_valid[i] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d] got %b want 0", i, o_valid[i]); end
      if (o_bit[i]   !== 1'b0) begin n_fail++; $display("FAIL reset_bit[%0d] got %b want 0", i, o_bit[i]); end
      if (o_noise[i] !== 1'b0) begin n_fail++; $display("FAIL reset_noise[%0d] got %b want 0", i, o_noise[i]); end
      if (o_cfg[i]   !== 1'b0) begin n_fail++; $display("FAIL reset_cfg[%0d] got %b want 0", i, o_cfg[i]); end
    end
    rst = 0; en = 1;
  endtask

  task automatic test_clean_bit();
    ps = 6'd8;
    for (int e = 0; e < 64; e++) rx_pat[e] = 1;
    clear_counts();
    period(8);
    n_run += 4;
    if (vcount[0] !== 1) begin n_fail++; $display("FAIL clean_count got %0d want 1", vcount[0]); end
    if (vat[0] !== 6) begin n_fail++; $display("FAIL clean_latency got edge %0d want 6", vat[0]); end
    if (o_bit[0] !== 1'b1) begin n_fail++; $display("FAIL clean_bit got %b want 1", o_bit[0]); end
    if (o_noise[0] !== 1'b0) begin n_fail++; $display("FAIL clean_noise got %b want 0", o_noise[0]); end
  endtask

  task automatic test_glitch();
    ps = 6'd16;
    for (int e = 0; e < 64; e++) rx_pat[e] = 0;
    rx_pat[6] = 1; rx_pat[7] = 0; rx_pat[8] = 1; rx_pat[9] = 1; rx_pat[10] = 0;
    clear_counts();
    period(16);
    n_run += 4;
    if (vcount[1] !== 1) begin n_fail++; $display("FAIL glitch1_count got %0d want 1", vcount[1]); end
    if (vat[1] !== 11) begin n_fail++; $display("FAIL glitch1_latency got edge %0d want 11", vat[1]); end
    if (o_bit[1] !== 1'b1) begin n_fail++; $display("FAIL glitch1_bit got %b want 1", o_bit[1]); end
    if (o_noise[1] !== 1'b1) begin n_fail++; $display("FAIL glitch1_noise got %b want 1", o_noise[1]); end
    rx_pat[6] = 0; rx_pat[7] = 0; rx_pat[8] = 1; rx_pat[9] = 0; rx_pat[10] = 0;
    clear_counts();
    period(16);
    n_run += 2;
    if (o_bit[1] !== 1'b0) begin n_fail++; $display("FAIL glitch2_bit got %b want 0", o_bit[1]); end
    if (o_noise[1] !== 1'b1) begin n_fail++; $display("FAIL glitch2_noise got %b want 1", o_noise[1]); end
  endtask

  task automatic test_stall();
    int eseq [10] = '{0, 1, 2, 3, 4, 4, 4, 5, 6, 7};
    bit rseq [10] = '{0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
    ps = 6'd8;
    clear_counts();
    for (int k = 0; k < 10; k++) begin
      ec = 6'(eseq[k]);
      rx = rseq[k];
      tick();
      if (o_valid[0]) begin vcount[0]++; vat[0] = eseq[k]; end
    end
    n_run += 4;
    if (vcount[0] !== 1) begin n_fail++; $display("FAIL stall_count got %0d want 1", vcount[0]); end
    if (vat[0] !== 6) begin n_fail++; $display("FAIL stall_latency got edge %0d want 6", vat[0]); end
    if (o_bit[0] !== 1'b1) begin n_fail++; $display("FAIL stall_bit got %b want 1", o_bit[0]); end
    if (o_noise[0] !== 1'b0) begin n_fail++; $display("FAIL stall_noise got %b want 0", o_noise[0]); end
  endtask

  task automatic test_cfg_err();
    ps = 6'd7;
    for (int e = 0; e < 64; e++) rx_pat[e] = 1;
    clear_counts();
    period(7); period(7); period(7);
    n_run += 2;
    if (o_cfg[1] !== 1'b1) begin n_fail++; $display("FAIL cfg_set got %b want 1", o_cfg[1]); end
    if (vcount[1] !== 0) begin n_fail++; $display("FAIL cfg_novote got %0d votes want 0", vcount[1]); end
    ps = 6'd8;
    clear_counts();
    period(8); period(8);
    n_run += 3;
    if (o_cfg[1] !== 1'b0) begin n_fail++; $display("FAIL cfg_clear got %b want 0", o_cfg[1]); end
    if (vcount[1] !== 2) begin n_fail++; $display("FAIL cfg_resume got %0d votes want 2", vcount[1]); end
    if (vat[1] !== 7) begin n_fail++; $display("FAIL cfg_latency got edge %0d want 7", vat[1]); end
  endtask

  task automatic test_enable_drop();
    ps = 6'd8;
    for (int e = 0; e < 64; e++) rx_pat[e] = 1;
    period(8);
    for (int e = 0; e < 64; e++) rx_pat[e] = 0;
    clear_counts();
    for (int e = 0; e < 8; e++) begin
      ec = 6'(e);
      rx = 0;
      en = (e != 4);
      tick();
      if (o_valid[0]) vcount[0]++;
    end
    en = 1;
    n_run += 2;
    if (vcount[0] !== 0) begin n_fail++; $display("FAIL endrop_novote got %0d votes want 0", vcount[0]); end
    if (o_bit[0] !== 1'b1) begin n_fail++; $display("FAIL endrop_hold got %b want 1", o_bit[0]); end
  endtask

  task automatic test_sync_reset();
    ps = 6'd8;
    for (int e = 0; e < 64; e++) rx_pat[e] = (e >= 2);
    clear_counts();
    period(8);
    n_run += 3;
    if (vcount[2] !== 1) begin n_fail++; $display("FAIL sync_count got %0d want 1", vcount[2]); end
    if (o_bit[2] !== 1'b1) begin n_fail++; $display("FAIL sync_bit got %b want 1", o_bit[2]); end
    if (o_noise[2] !== 1'b1) begin n_fail++; $display("FAIL sync_first_sample got noise %b want 1", o_noise[2]); end
    clear_counts();
    for (int e = 0; e < 8; e++) begin
      ec = 6'(e);
      rx = 1;
      rst = (e == 5);
      tick();
      if (e == 5) begin
        for (int i = 0; i < 3; i++) begin
          n_run += 4;
          if (o_valid[i] !== 1'b0) begin n_fail++; $display("FAIL midrst_valid[%0d] got %b want 0", i, o_valid[i]); end
          if (o_bit[i]   !== 1'b0) begin n_fail++; $display("FAIL midrst_bit[%0d] got %b want 0", i, o_bit[i]); end
          if (o_noise[i] !== 1'b0) begin n_fail++; $display("FAIL midrst_noise[%0d] got %b want 0", i, o_noise[i]); end
          if (o_cfg[i]   !== 1'b0) begin n_fail++; $display("FAIL midrst_cfg[%0d] got %b want 0", i, o_cfg[i]); end
        end
      end else if (e > 5) begin
        for (int i = 0; i < 3; i++) if (o_valid[i]) vcount[i]++;
      end
    end
    rst = 0;
    n_run += 1;
    if (vcount[0] + vcount[1] + vcount[2] !== 0) begin
      n_fail++; $display("FAIL midrst_novote got %0d votes want 0", vcount[0] + vcount[1] + vcount[2]);
    end
  endtask

  task automatic test_random();
    int p, e;
    for (int per = 0; per < 40; per++) begin
      p = $urandom_range(4, 24);
      ps = 6'(p);
      e = 0;
      while (e < p) begin
        ec = 6'(e);
        rx = 1'($urandom_range(0, 1));
        en = ($urandom_range(0, 19) != 0);
        tick();
        for (int i = 0; i < 3; i++) begin
          n_run += 4;
          if (o_valid[i] !== m_valid[i]) begin n_fail++; $display("FAIL rand_valid[%0d] edge %0d got %b want %b", i, e, o_valid[i], m_valid[i]); end
          if (o_bit[i]   !== m_bit[i])   begin n_fail++; $display("FAIL rand_bit[%0d] edge %0d got %b want %b", i, e, o_bit[i], m_bit[i]); end
          if (o_noise[i] !== m_noise[i]) begin n_fail++; $display("FAIL rand_noise[%0d] edge %0d got %b want %b", i, e, o_noise[i], m_noise[i]); end
          if (o_cfg[i]   !== m_cfg[i])   begin n_fail++; $display("FAIL rand_cfg[%0d] edge %0d got %b want %b", i, e, o_cfg[i], m_cfg[i]); end
        end
        if ($urandom_range(0, 3) != 0) e++;
      end
    end
    en = 1;
  endtask

  initial begin
    ns_tab[0] = 3; ns_tab[1] = 5; ns_tab[2] = 3;
    sy_tab[0] = 0; sy_tab[1] = 0; sy_tab[2] = 1;
    test_reset();
    test_clean_bit();
    test_glitch();
    test_stall();
    test_cfg_err();
    test_enable_drop();
    test_sync_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
